// File: rtl/instr_mem_pipelined.sv
// Clocked byte-addressed instruction memory: self-fills with NOP after reset,
// byte-serial load port, pipelined fetch with fixed latency, flush and error reporting.
module instr_mem_pipelined #(
  parameter int ADDR_W    = 32,
  parameter int INST_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 1,
  parameter logic [INST_W-1:0] NOP_WORD = 32'hE0000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [BYTE_W-1:0] load_data,
  output logic              init_done,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [INST_W-1:0] rsp_inst,
  output logic              rsp_err
);

  localparam int NB    = INST_W / BYTE_W;
  localparam int NW    = MEM_BYTES / NB;
  localparam int MA_W  = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  // Byte k of the fill word, k=0 being the most significant (big-endian).
  function automatic logic [BYTE_W-1:0] nop_byte(input int k);
    return NOP_WORD[INST_W-1-k*BYTE_W -: BYTE_W];
  endfunction

  logic [BYTE_W-1:0] mem_q [MEM_BYTES];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic              init_done_q, init_done_d;
  logic              v_q    [LATENCY];
  logic              v_d    [LATENCY];
  logic [INST_W-1:0] inst_q [LATENCY];
  logic [INST_W-1:0] inst_d [LATENCY];
  logic              err_q  [LATENCY];
  logic              err_d  [LATENCY];

  logic              fill_we_s, load_we_s, accept_s, req_err_s;
  logic [MA_W-1:0]   fill_base_s;
  logic [INST_W-1:0] raw_inst_s, req_inst_s;

  // Write/read decode and request classification.
  always_comb begin
    fill_we_s   = (state_q == ST_INIT);
    fill_base_s = MA_W'(fill_cnt_q) * MA_W'(NB);
    load_we_s   = (state_q == ST_RUN) && load_en && ({1'b0, load_addr} < MEM_LIM);
    req_ready   = init_done_q & ~load_en;
    accept_s    = req_valid & req_ready;
    req_err_s   = ((req_addr % ADDR_W'(NB)) != {ADDR_W{1'b0}}) ||
                  (({1'b0, req_addr} + (ADDR_W+1)'(NB-1)) >= MEM_LIM);
    raw_inst_s  = NOP_WORD;
    for (int k = 0; k < NB; k++) begin
      raw_inst_s[INST_W-1-k*BYTE_W -: BYTE_W] = mem_q[req_addr[MA_W-1:0] + MA_W'(k)];
    end
    req_inst_s  = req_err_s ? NOP_WORD : raw_inst_s;
  end

  // Latency pipeline; payload only moves with a surviving valid so outputs hold.
  always_comb begin
    v_d[0]   = accept_s & ~flush;
    inst_d[0] = v_d[0] ? req_inst_s : inst_q[0];
    err_d[0]  = v_d[0] ? req_err_s  : err_q[0];
    for (int i = 1; i < LATENCY; i++) begin
      v_d[i]    = v_q[i-1] & ~flush;
      inst_d[i] = v_d[i] ? inst_q[i-1] : inst_q[i];
      err_d[i]  = v_d[i] ? err_q[i-1]  : err_q[i];
    end
  end

  // Fill sequencer: one word per cycle, then run.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
        if (fill_cnt_q == CNT_W'(NW-1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      fill_cnt_q  <= {CNT_W{1'b0}};
      init_done_q <= 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
        v_q[i]    <= 1'b0;
        inst_q[i] <= NOP_WORD;
        err_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      init_done_q <= init_done_d;
      for (int i = 0; i < LATENCY; i++) begin
        v_q[i]    <= v_d[i];
        inst_q[i] <= inst_d[i];
        err_q[i]  <= err_d[i];
      end
    end
  end

  // Storage array; contents are established by the fill, not by reset.
  always_ff @(posedge clk) begin
    if (fill_we_s) begin
      for (int k = 0; k < NB; k++) begin
        mem_q[fill_base_s + MA_W'(k)] <= nop_byte(k);
      end
    end else if (load_we_s) begin
      mem_q[load_addr[MA_W-1:0]] <= load_data;
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_inst  = inst_q[LATENCY-1];
  assign rsp_err   = err_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed bench: two instances (LATENCY=1 and LATENCY=3, 64 bytes) share stimulus.
module tb_instr_mem_pipelined;
  localparam logic [31:0] NOP = 32'hE0000000;

  logic        clk = 1'b0;
  logic        rst, load_en, req_valid, flush;
  logic [31:0] load_addr, req_addr;
  logic [7:0]  load_data;
  logic        a_init, a_rdy, a_vld, a_err;
  logic [31:0] a_inst;
  logic        b_init, b_rdy, b_vld, b_err;
  logic [31:0] b_inst;
  int          errors = 0;
  int          checks = 0;
  int          n;
  logic [7:0]  tbl [12];

  always #5 clk = ~clk;

  instr_mem_pipelined #(.MEM_BYTES(64), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .init_done(a_init), .req_valid(req_valid), .req_addr(req_addr), .req_ready(a_rdy),
    .flush(flush), .rsp_valid(a_vld), .rsp_inst(a_inst), .rsp_err(a_err));

  instr_mem_pipelined #(.MEM_BYTES(64), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .init_done(b_init), .req_valid(req_valid), .req_addr(req_addr), .req_ready(b_rdy),
    .flush(flush), .rsp_valid(b_vld), .rsp_inst(b_inst), .rsp_err(b_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rsp1(input string tag, input logic v, input logic [31:0] inst, input logic e);
    chk({tag, "_l1_vld"}, 64'(a_vld), 64'(v));
    if (v) begin
      chk({tag, "_l1_inst"}, 64'(a_inst), 64'(inst));
      chk({tag, "_l1_err"}, 64'(a_err), 64'(e));
    end
  endtask

  task automatic rsp3(input string tag, input logic v, input logic [31:0] inst, input logic e);
    chk({tag, "_l3_vld"}, 64'(b_vld), 64'(v));
    if (v) begin
      chk({tag, "_l3_inst"}, 64'(b_inst), 64'(inst));
      chk({tag, "_l3_err"}, 64'(b_err), 64'(e));
    end
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (!a_init && cnt < 40) begin
      chk("init_rdy_low", 64'({a_rdy, b_rdy}), 64'h0);
      chk("init_no_rsp", 64'({a_vld, b_vld}), 64'h0);
      tick();
      cnt++;
    end
    req_valid = 1'b0;
    load_en   = 1'b0;
  endtask

  initial begin
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hB2, 8'hC3, 8'hD4,
            8'hDE, 8'hAD, 8'hBE, 8'hEF};
    rst = 1'b0; load_en = 1'b0; load_addr = 32'd0; load_data = 8'h00;
    req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_init_done", 64'({a_init, b_init}), 64'h0);
    chk("rst_ready", 64'({a_rdy, b_rdy}), 64'h0);
    chk("rst_vld", 64'({a_vld, b_vld}), 64'h0);
    chk("rst_inst_l1", 64'(a_inst), 64'(NOP));
    chk("rst_inst_l3", 64'(b_inst), 64'(NOP));

    // Fill: requests and loads presented throughout must be ignored.
    rst = 1'b1; req_valid = 1'b1; req_addr = 32'd0;
    load_en = 1'b1; load_addr = 32'd0; load_data = 8'h55;
    wait_init(n);
    chk("init_cycles", 64'(n), 64'd16);
    chk("init_done_l3", 64'(b_init), 64'h1);

    // Fetch 0 after fill.
    req_valid = 1'b1; req_addr = 32'd0; #1;
    chk("ready_run", 64'({a_rdy, b_rdy}), 64'h3);
    tick(); req_valid = 1'b0;
    rsp1("t1", 1'b1, NOP, 1'b0); rsp3("t1a", 1'b0, NOP, 1'b0);
    tick(); rsp1("t1b", 1'b0, NOP, 1'b0); rsp3("t1b", 1'b0, NOP, 1'b0);
    tick(); rsp3("t1", 1'b1, NOP, 1'b0);

    // Load E3 A0 00 14 at 0..3 while a request is held: load wins.
    req_valid = 1'b1; req_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1; load_addr = 32'(i);
      load_data = (i == 0) ? 8'hE3 : (i == 1) ? 8'hA0 : (i == 2) ? 8'h00 : 8'h14;
      #1;
      chk("load_ready_low", 64'({a_rdy, b_rdy}), 64'h0);
      tick();
      chk("load_no_rsp_l1", 64'(a_vld), 64'h0);
    end
    load_en = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("load_no_rsp_l3", 64'({a_vld, b_vld}), 64'h0);
    end
    req_valid = 1'b1; req_addr = 32'd0;
    tick(); req_valid = 1'b0;
    rsp1("t2", 1'b1, 32'hE3A00014, 1'b0);
    tick(); tick(); rsp3("t2", 1'b1, 32'hE3A00014, 1'b0);

    // Load words at 4, 8, 12, plus an out-of-range byte that must be dropped.
    for (int i = 0; i < 12; i++) begin
      load_en = 1'b1; load_addr = 32'(i + 4); load_data = tbl[i];
      tick();
    end
    load_addr = 32'd72; load_data = 8'h00;
    tick(); load_en = 1'b0;

    // Back-to-back fetches 0, 4, 8.
    req_valid = 1'b1; req_addr = 32'd0; tick();
    req_addr = 32'd4; rsp1("t3_0", 1'b1, 32'hE3A00014, 1'b0); tick();
    req_addr = 32'd8; rsp1("t3_4", 1'b1, 32'h11223344, 1'b0); tick();
    req_valid = 1'b0;
    rsp1("t3_8", 1'b1, 32'hA1B2C3D4, 1'b0); rsp3("t3_0", 1'b1, 32'hE3A00014, 1'b0);
    tick(); rsp1("t3_idle", 1'b0, NOP, 1'b0); rsp3("t3_4", 1'b1, 32'h11223344, 1'b0);
    chk("t3_hold_l1", 64'(a_inst), 64'hA1B2C3D4);
    tick(); rsp3("t3_8", 1'b1, 32'hA1B2C3D4, 1'b0);
    tick(); rsp3("t3_idle", 1'b0, NOP, 1'b0);

    // Errors: misaligned and out of range; then last legal word and memory intact.
    req_valid = 1'b1; req_addr = 32'd2; tick();
    req_addr = 32'd64; rsp1("t4_mis", 1'b1, NOP, 1'b1); tick();
    req_addr = 32'd60; rsp1("t4_oor", 1'b1, NOP, 1'b1); tick();
    req_addr = 32'd8; rsp1("t4_last", 1'b1, NOP, 1'b0); rsp3("t4_mis", 1'b1, NOP, 1'b1); tick();
    req_addr = 32'hFFFF_FFFC; rsp1("t4_mem", 1'b1, 32'hA1B2C3D4, 1'b0); rsp3("t4_oor", 1'b1, NOP, 1'b1); tick();
    req_valid = 1'b0; rsp1("t4_wrap", 1'b1, NOP, 1'b1); rsp3("t4_last", 1'b1, NOP, 1'b0);
    tick(); rsp3("t4_mem", 1'b1, 32'hA1B2C3D4, 1'b0);
    tick(); rsp3("t4_wrap", 1'b1, NOP, 1'b1);
    tick(); rsp3("t4_idle", 1'b0, NOP, 1'b0);
    chk("t4_hold_err_l3", 64'(b_err), 64'h1);

    // Flush in the cycle that accepts 8.
    req_valid = 1'b1; req_addr = 32'd0; tick();
    req_addr = 32'd4; tick();
    req_addr = 32'd8; flush = 1'b1;
    rsp1("t5_pre", 1'b1, 32'h11223344, 1'b0);
    tick(); flush = 1'b0; req_addr = 32'd12;
    rsp1("t5_f", 1'b0, NOP, 1'b0); rsp3("t5_f0", 1'b0, NOP, 1'b0);
    tick(); req_valid = 1'b0;
    rsp1("t5_12", 1'b1, 32'hDEADBEEF, 1'b0); rsp3("t5_f1", 1'b0, NOP, 1'b0);
    tick(); rsp3("t5_f2", 1'b0, NOP, 1'b0);
    tick(); rsp3("t5_12", 1'b1, 32'hDEADBEEF, 1'b0);

    // Reset with two fetches in flight, then refill.
    req_valid = 1'b1; req_addr = 32'd0; tick();
    req_addr = 32'd4; tick();
    req_valid = 1'b0; rst = 1'b0; #1;
    chk("t6_vld", 64'({a_vld, b_vld}), 64'h0);
    chk("t6_init", 64'({a_init, b_init}), 64'h0);
    chk("t6_inst", 64'(b_inst), 64'(NOP));
    tick(); tick();
    rst = 1'b1;
    wait_init(n);
    chk("t6_init_cycles", 64'(n), 64'd16);
    req_valid = 1'b1; req_addr = 32'd0; tick(); req_valid = 1'b0;
    rsp1("t6_refill", 1'b1, NOP, 1'b0);
    tick(); tick(); rsp3("t6_refill", 1'b1, NOP, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
